// File: rtl/uart_reg_master_if.sv
// Request/response bus between a requester and uart_reg_master.
// Handshake: a request transfers on any cycle where req_valid_in & req_ready_out; the requester holds req_* stable until then, and rsp_valid_out is a one-cycle pulse with no back-pressure.
`timescale 1ns/1ps
interface uart_reg_master_if;
  logic       req_valid_in;
  logic       req_ready_out;
  logic       req_rw_in;
  logic [6:0] req_addr_in;
  logic [7:0] req_wdata_in;
  logic       rsp_valid_out;
  logic [7:0] rsp_rdata_out;
  logic       rsp_timeout_out;
  logic       busy_out;

  modport master (
    output req_valid_in, req_rw_in, req_addr_in, req_wdata_in,
    input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_timeout_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_rw_in, req_addr_in, req_wdata_in,
    output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_timeout_out, busy_out
  );
endinterface

// File: rtl/uart_reg_master.sv
// Host-side initiator for the UART register protocol: sends header (+ write data) frames
// on tx_out and, for reads, collects one reply byte from rx_in with a timeout.
`timescale 1ns/1ps
module uart_reg_master #(
  parameter int CLKS_PER_BIT = 142,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic                clk_in,
  input  logic                rst_in_n,
  uart_reg_master_if.slave    bus,
  output logic                tx_out,
  input  logic                rx_in,
  output logic [2:0]          state_dbg_out
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX_HDR  = 3'd1,
    S_TX_DATA = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  state_t          state_q, state_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [CW-1:0]   tx_clk_q, tx_clk_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            to_flag_q, to_flag_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rw_q, rw_d;
  logic [7:0]      wdata_q, wdata_d;

  rx_state_t       rx_state_q, rx_state_d;
  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [CW-1:0]   rx_clk_q, rx_clk_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_done;

  // The stop-bit sample is only a valid byte when the line reads high there.
  assign rx_done = (rx_state_q == R_STOP) && (rx_clk_q == CPB_M1) && rx_sync2_q;

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    tx_clk_d   = tx_clk_q;
    tx_bit_d   = tx_bit_q;
    to_cnt_d   = to_cnt_q;
    to_flag_d  = to_flag_q;
    rdata_d    = rdata_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_in) begin
          rw_d       = bus.req_rw_in;
          wdata_d    = bus.req_wdata_in;
          tx_shift_d = {1'b1, ~bus.req_rw_in, bus.req_addr_in, 1'b0};
          tx_clk_d   = '0;
          tx_bit_d   = '0;
          state_d    = S_TX_HDR;
        end
      end
      S_TX_HDR, S_TX_DATA: begin
        if (tx_clk_q == CPB_M1) begin
          tx_clk_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (state_q == S_TX_HDR && !rw_q) begin
              // Data frame starts right after the header stop bit, no idle gap.
              tx_shift_d = {1'b1, wdata_q, 1'b0};
              state_d    = S_TX_DATA;
            end else if (state_q == S_TX_HDR) begin
              tx_shift_d = '1;
              to_cnt_d   = '0;
              state_d    = S_WAIT;
            end else begin
              tx_shift_d = '1;
              to_flag_d  = 1'b0;
              state_d    = S_DONE;
            end
          end else begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_clk_d = tx_clk_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (rx_done) begin
          rdata_d   = rx_shift_q;
          to_flag_d = 1'b0;
          state_d   = S_DONE;
        end else if (to_cnt_q == TO_M1) begin
          to_flag_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_clk_d   = rx_clk_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    if (state_q != S_WAIT) begin
      rx_state_d = R_IDLE;
    end else begin
      case (rx_state_q)
        R_IDLE: begin
          if (rx_prev_q && !rx_sync2_q) begin
            rx_clk_d   = '0;
            rx_state_d = R_START;
          end
        end
        R_START: begin
          if (rx_clk_q == HALF_M1) begin
            rx_clk_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync2_q ? R_IDLE : R_DATA;
          end else begin
            rx_clk_d = rx_clk_q + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_clk_q == CPB_M1) begin
            rx_clk_d   = '0;
            rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_clk_d = rx_clk_q + 1'b1;
          end
        end
        R_STOP: begin
          if (rx_clk_q == CPB_M1) begin
            rx_clk_d   = '0;
            rx_state_d = R_IDLE;
          end else begin
            rx_clk_d = rx_clk_q + 1'b1;
          end
        end
        default: rx_state_d = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q    <= S_IDLE;
      tx_shift_q <= '1;
      tx_clk_q   <= '0;
      tx_bit_q   <= '0;
      to_cnt_q   <= '0;
      to_flag_q  <= 1'b0;
      rdata_q    <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      rx_state_q <= R_IDLE;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_clk_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      tx_clk_q   <= tx_clk_d;
      tx_bit_q   <= tx_bit_d;
      to_cnt_q   <= to_cnt_d;
      to_flag_q  <= to_flag_d;
      rdata_q    <= rdata_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rx_state_q <= rx_state_d;
      rx_sync1_q <= rx_in;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_clk_q   <= rx_clk_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign tx_out              = tx_shift_q[0];
  assign bus.req_ready_out   = (state_q == S_IDLE);
  assign bus.busy_out        = (state_q != S_IDLE);
  assign bus.rsp_valid_out   = (state_q == S_DONE);
  assign bus.rsp_timeout_out = (state_q == S_DONE) && to_flag_q;
  assign bus.rsp_rdata_out   = rdata_q;
  assign state_dbg_out       = state_q;

endmodule

// File: doc/uart_reg_master.md
Name: uart_reg_master

Overview:
- Host-side initiator for the UART register-access protocol served by the register bank: turns a parallel read/write request into command frames on tx_out and collects the read reply from rx_in.
- Used in bring-up and loopback builds: the master drives a reg_bank over its UART pins, so the register path is exercised without a PC.
- Self-contained 8N1 serializer/deserializer plus a sequencing FSM and a reply timeout.

Parameters:
CLKS_PER_BIT, 142, clocks per UART bit; must be >= 4.
TIMEOUT_CLKS, 20000, clocks to wait for the read reply, counted from the end of the header stop bit.

Ports:
clk_in  input  1  system clock.
rst_in_n  input  1  reset, asynchronous, active-low.
req_valid_in  input  1  request strobe; accepted when req_ready_out=1.
req_ready_out  output  1  high only in IDLE.
req_rw_in  input  1  1=read, 0=write.
req_addr_in  input  7  register address.
req_wdata_in  input  8  write data; ignored for reads.
rsp_valid_out  output  1  one-cycle pulse at transaction end.
rsp_rdata_out  output  8  read data; valid with rsp_valid_out; holds its value until the next read completes.
rsp_timeout_out  output  1  qualifies rsp_valid_out: read reply not received.
busy_out  output  1  equals ~req_ready_out.
tx_out  output  1  UART line to responder, idle high.
rx_in  input  1  UART line from responder, asynchronous.

Behaviour:
- Reset: asynchronous and active-low. All outputs go to these values immediately: tx_out=1, req_ready_out=1, busy_out=0, rsp_valid_out=0, rsp_timeout_out=0, rsp_rdata_out=0x00. FSM goes to IDLE; all counters are cleared.
- Frame format:
  - header byte = {~req_rw_in, req_addr_in}, so bit7=1 means write.
  - A write sends the header byte followed by the wdata byte.
  - A read sends the header byte only; the responder returns one data byte.
- Request capture: rw, addr and wdata are registered on the accept cycle (req_valid_in & req_ready_out). Input changes after acceptance have no effect.
- UART TX, 8N1, LSB first:
  - Each bit is held for exactly CLKS_PER_BIT clocks.
  - The start bit begins on the cycle after acceptance; a byte occupies 10*CLKS_PER_BIT clocks.
  - For writes, the data byte's start bit follows the header stop bit with no idle gap.
- UART RX:
  - rx_in passes through a 2-flop synchronizer.
  - A falling edge starts a byte. The line is sampled at CLKS_PER_BIT/2 (integer division); if it is not low there, the start is rejected and the receiver returns to idle.
  - Data bits are sampled every CLKS_PER_BIT clocks after that.
  - If the stop bit samples 0 (framing error), the byte is discarded and the receiver keeps waiting.
  - The receiver runs only in WAIT_RSP; bytes arriving in other states are ignored. A byte already in progress when WAIT_RSP is entered is not captured.
- FSM states: IDLE -> TX_HDR -> (write: TX_DATA -> DONE | read: WAIT_RSP -> DONE) -> IDLE.
  - WAIT_RSP:
    - Valid byte received: rsp_rdata_out is loaded and the FSM goes to DONE with timeout=0.
    - Timeout counter reaches TIMEOUT_CLKS: the FSM goes to DONE with timeout=1 and rsp_rdata_out unchanged.
    - A byte whose stop bit is sampled on the same cycle the timeout expires counts as received; reception wins.
  - DONE lasts one cycle and drives rsp_valid_out=1. rsp_timeout_out is valid only in that cycle and is 0 otherwise. The next cycle is IDLE, so req_ready_out returns one cycle after the rsp pulse.
- Latency, accept cycle to rsp_valid_out:
  - write: 20*CLKS_PER_BIT+1 clocks.
  - read timeout: 10*CLKS_PER_BIT+TIMEOUT_CLKS+1 clocks.
- Requests while busy: req_ready_out=0; requests are neither queued nor dropped silently, and the requester must hold req_valid_in.
- Reset mid-operation: tx_out returns high asynchronously, a partial frame is abandoned, and no rsp pulse is produced.

Test Plan:
- Write: accept addr=0x05, wdata=0xA5 with CLKS_PER_BIT=4 -> tx_out carries header 0x85 then 0xA5, each as start 0, LSB-first bits, stop 1, 4 clocks per bit; rsp_valid_out pulses at cycle 81 after accept with rsp_timeout_out=0.
- Read: accept addr=0x12 -> header 0x12 sent; bench responder returns 0x3C on rx_in 3 bit-times later -> rsp_valid_out=1, rsp_rdata_out=0x3C, rsp_timeout_out=0.
- Timeout: read with rx_in held high, TIMEOUT_CLKS=100 -> rsp_valid_out and rsp_timeout_out pulse together at cycle 141 after accept; rsp_rdata_out holds its previous value.
- RX robustness: during WAIT_RSP, inject a 1-clock low glitch -> ignored; then a byte 0x7E with stop bit=0 -> discarded; then a clean 0x7E -> rsp_rdata_out=0x7E.
- Busy/handshake: hold req_valid_in through a write -> req_ready_out stays 0 until 1 cycle after the rsp pulse; the second request is then accepted and its header reflects the new inputs.
- Reset: assert rst_in_n=0 mid-way through the header data bits -> tx_out=1 in the same cycle; after release, no rsp_valid_out pulse and req_ready_out=1.
